// File: rtl/ps2_direction_latch.sv
// ps2_direction_latch
//   Per-player steering latch for the light-bike game. Decodes the PS/2 byte
//   stream (E0 extended prefix, F0 break prefix), maps make codes to each
//   player's up/right/down/left, holds every bike's heading, and refuses
//   reversals and second turns inside one movement tick.
//
//   Parameters
//     NUM_PLAYERS    active players (1..4); keys for other players are ignored
//     INIT_DIR       reset heading, 2 bits per player, player p at [2p+1:2p]
//     PREFIX_TIMEOUT idle cycles a pending prefix survives (>= 1)
//     ALLOW_REVERSE  1 lets a bike turn straight back (still one turn per tick)
//
//   Ports
//     clock        system clock
//     reset        synchronous, active-high
//     scan_code    byte from the PS/2 receiver
//     scan_valid   1-cycle strobe qualifying scan_code
//     tick         1-cycle strobe, bikes advance one cell
//     dir          heading per player: 00 up, 01 right, 10 down, 11 left
//     dir_changed  1-cycle pulse per player whose heading was updated
//     turn_locked  player has already turned since the last tick
module ps2_direction_latch #(
  parameter int         NUM_PLAYERS    = 4,
  parameter logic [7:0] INIT_DIR       = 8'h00,
  parameter int         PREFIX_TIMEOUT = 1000,
  parameter bit         ALLOW_REVERSE  = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 scan_code,
  input  logic                       scan_valid,
  input  logic                       tick,
  output logic [2*NUM_PLAYERS-1:0]   dir,
  output logic [NUM_PLAYERS-1:0]     dir_changed,
  output logic [NUM_PLAYERS-1:0]     turn_locked
);

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PREFIX_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // Returns {hit, player[1:0], heading[1:0]} for a make code. Players 0-2
  // only respond to plain codes, player 3 only to E0-prefixed codes, so the
  // keypad arrows sent without E0 fall through as misses.
  function automatic logic [4:0] decode_key(input logic [7:0] code, input logic ext);
    logic [4:0] r;
    r = 5'b0_00_00;
    if (!ext) begin
      case (code)
        8'h1D: r = 5'b1_00_00;
        8'h23: r = 5'b1_00_01;
        8'h1B: r = 5'b1_00_10;
        8'h1C: r = 5'b1_00_11;
        8'h2C: r = 5'b1_01_00;
        8'h33: r = 5'b1_01_01;
        8'h34: r = 5'b1_01_10;
        8'h2B: r = 5'b1_01_11;
        8'h43: r = 5'b1_10_00;
        8'h4B: r = 5'b1_10_01;
        8'h42: r = 5'b1_10_10;
        8'h3B: r = 5'b1_10_11;
        default: r = 5'b0_00_00;
      endcase
    end else begin
      case (code)
        8'h75: r = 5'b1_11_00;
        8'h74: r = 5'b1_11_01;
        8'h72: r = 5'b1_11_10;
        8'h6B: r = 5'b1_11_11;
        default: r = 5'b0_00_00;
      endcase
    end
    return r;
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [2*NUM_PLAYERS-1:0]   dir_q, dir_d;
  logic [NUM_PLAYERS-1:0]     changed_q, changed_d;
  logic [NUM_PLAYERS-1:0]     lock_q, lock_d;

  logic       make_hit;
  logic       make_ext;
  logic [4:0] key;
  logic       key_hit;
  logic [1:0] key_player;
  logic [1:0] key_dir;
  logic [1:0] cur_dir;
  logic       cur_lock;
  logic       player_ok;
  logic       accept;

  // Prefix FSM and idle timer
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    make_hit = 1'b0;
    make_ext = 1'b0;
    if (scan_valid) begin
      timer_d = '0;
      case (state_q)
        S_IDLE: begin
          if (scan_code == CODE_EXT)      state_d = S_EXT;
          else if (scan_code == CODE_BRK) state_d = S_BRK;
          else                            make_hit = 1'b1;
        end
        S_EXT: begin
          if (scan_code == CODE_BRK)      state_d = S_EXT_BRK;
          else if (scan_code == CODE_EXT) state_d = S_EXT;
          else begin
            make_hit = 1'b1;
            make_ext = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;  // break states swallow the released key
      endcase
    end else if (state_q != S_IDLE) begin
      // A prefix whose follow-up byte never arrives is dropped.
      if (timer_q == TIMER_LAST) begin
        state_d = S_IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  assign key        = decode_key(scan_code, make_ext);
  assign key_hit    = make_hit & key[4];
  assign key_player = key[3:2];
  assign key_dir    = key[1:0];

  // Select the addressed player's current heading and lock.
  always_comb begin
    cur_dir   = 2'b00;
    cur_lock  = 1'b0;
    player_ok = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (key_player == 2'(p)) begin
        cur_dir   = dir_q[2*p +: 2];
        cur_lock  = lock_q[p];
        player_ok = 1'b1;
      end
    end
  end

  assign accept = key_hit && player_ok && !cur_lock && (key_dir != cur_dir) &&
                  (ALLOW_REVERSE || (key_dir != (cur_dir ^ 2'b10)));

  // A tick and an accepted turn in the same cycle leave the lock set: the
  // turn counts against the interval that starts with this tick.
  always_comb begin
    dir_d     = dir_q;
    changed_d = '0;
    lock_d    = tick ? '0 : lock_q;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (accept && (key_player == 2'(p))) begin
        dir_d[2*p +: 2] = key_dir;
        changed_d[p]    = 1'b1;
        lock_d[p]       = 1'b1;
      end
    end
  end

  // Registered state, one cycle after the completing byte
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      dir_q     <= INIT_DIR[2*NUM_PLAYERS-1:0];
      changed_q <= '0;
      lock_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      changed_q <= changed_d;
      lock_q    <= lock_d;
    end
  end

  assign dir         = dir_q;
  assign dir_changed = changed_q;
  assign turn_locked = lock_q;

endmodule
